// File: rtl/inst_cache_dm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_cache_dm_if                                             |
// | Description : sram-like instruction port bundle (request/address/data      |
// |               handshakes) shared by the core side and the AXI bridge side. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface inst_cache_dm_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Requester side: drives the request, receives the handshakes and data.
  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Responder side: receives the request, drives the handshakes and data.
  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/inst_cache_dm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_cache_dm                                                |
// | Description : Direct-mapped read-only instruction cache, one word per      |
// |               line, with saturating hit/miss counters.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inst_cache_dm #(
  parameter int INDEX_WIDTH = 10
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  inst_cache_dm_if.slave   cpu_inst,
  inst_cache_dm_if.master  cache_inst,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
);

  localparam int c_num_lines = 2 ** INDEX_WIDTH;
  localparam int c_tag_width = 30 - INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    REFILL = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [29:0]             r_addr;        // latched word address of the request
  logic [c_num_lines-1:0]  r_valid;
  logic [c_tag_width-1:0]  r_tag_mem  [c_num_lines];
  logic [31:0]             r_data_mem [c_num_lines];

  // Line contents captured at accept so the arrays can map onto synchronous RAM.
  logic                    r_valid_rd;
  logic [c_tag_width-1:0]  r_tag_rd;
  logic [31:0]             r_data_rd;

  logic [31:0]             r_rdata;
  logic [31:0]             r_hit_cnt;
  logic [31:0]             r_miss_cnt;

  logic [INDEX_WIDTH-1:0]  w_cpu_idx;
  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [c_tag_width-1:0]  w_tag;
  logic                    w_accept;
  logic                    w_hit;
  logic                    w_fill;
  logic                    w_addr_ok;
  logic                    w_data_ok;
  logic                    w_cache_req;
  logic [31:0]             w_rdata;
  logic                    w_unused;

  assign w_cpu_idx = cpu_inst.addr[INDEX_WIDTH+1:2];
  assign w_idx     = r_addr[INDEX_WIDTH-1:0];
  assign w_tag     = r_addr[29:INDEX_WIDTH];
  assign w_accept  = (r_state == IDLE) && cpu_inst.req;
  assign w_hit     = r_valid_rd && (r_tag_rd == w_tag);
  assign w_fill    = (r_state == REFILL) && cache_inst.data_ok;

  // Write-related and byte-offset inputs carry no meaning for a word-read cache.
  assign w_unused = ^{cpu_inst.wr, cpu_inst.size, cpu_inst.wdata, cpu_inst.addr[1:0]};

  // State register; reset drops any in-flight refill on the spot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/data outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_ok   = 1'b0;
    w_data_ok   = 1'b0;
    w_cache_req = 1'b0;
    w_rdata     = r_rdata;
    case (r_state)
      IDLE: begin
        w_addr_ok = cpu_inst.req;
        if (cpu_inst.req) begin
          w_state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (w_hit) begin
          w_data_ok   = 1'b1;
          w_rdata     = r_data_rd;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = MISS;
        end
      end
      MISS: begin
        w_cache_req = 1'b1;
        if (cache_inst.addr_ok) begin
          w_state_nxt = REFILL;
        end
      end
      REFILL: begin
        if (cache_inst.data_ok) begin
          w_data_ok   = 1'b1;
          w_rdata     = cache_inst.rdata;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request address, valid bits, returned-data hold register and counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_valid    <= '0;
      r_rdata    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_rdata <= w_rdata;
      if (w_accept) begin
        r_addr <= cpu_inst.addr[31:2];
      end
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
      end
      if ((r_state == LOOKUP) && w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if ((r_state == LOOKUP) && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  // Tag/data arrays: read on accept, written on refill completion; never reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_valid_rd <= r_valid[w_cpu_idx];
      r_tag_rd   <= r_tag_mem[w_cpu_idx];
      r_data_rd  <= r_data_mem[w_cpu_idx];
    end
    if (w_fill) begin
      r_tag_mem[w_idx]  <= w_tag;
      r_data_mem[w_idx] <= cache_inst.rdata;
    end
  end

  assign cpu_inst.addr_ok = w_addr_ok;
  assign cpu_inst.data_ok = w_data_ok;
  assign cpu_inst.rdata   = w_rdata;

  assign cache_inst.req   = w_cache_req;
  assign cache_inst.wr    = 1'b0;
  assign cache_inst.size  = 2'b10;
  assign cache_inst.addr  = {r_addr, 2'b00};
  assign cache_inst.wdata = 32'd0;

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire
